// File: rtl/dmem_pkg.sv
// Shared types and size encodings for the data-memory load/store unit.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  // funct3 size codes as seen on the core side and on the dmem port
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    case (size)
      SZ_B, SZ_BU: return 3'd1;
      SZ_H, SZ_HU: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_chk.sv
// Combinational access checker: flags region, size-code and end-of-memory
// violations before a request is allowed to reach dmem.
module dmem_lsu_chk
  import dmem_pkg::*;
#(
  parameter int          DEPTH  = 128,
  parameter logic [3:0]  REGION = 4'h1
) (
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic        we,
  output logic        err
);

  localparam logic [28:0] LIMIT = 29'(DEPTH * 1024);

  logic        size_ok;
  logic        store_ok;
  logic        region_ok;
  logic [28:0] last_byte;

  assign size_ok   = size inside {SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU};
  assign store_ok  = !(we && (size == SZ_BU || size == SZ_HU));
  assign region_ok = (addr[31:28] == REGION);

  // One extra bit so an access touching the top of the 28-bit window cannot wrap.
  assign last_byte = {1'b0, addr[27:0]} + {26'd0, size_bytes(size)} - 29'd1;

  assign err = !(size_ok && store_ok && region_ok && (last_byte < LIMIT));

endmodule

// File: rtl/dmem_lsu.sv
// Single-outstanding load/store initiator for dmem with a one-cycle
// registered read, early error rejection and per-type completion counters.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int          DEPTH  = 128,
  parameter logic [3:0]  REGION = 4'h1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,

  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,

  output logic [31:0] mem_wData,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_size,
  output logic        mem_wEn,
  input  logic [31:0] mem_rData,

  output logic [31:0] load_count,
  output logic [31:0] store_count,
  output logic [31:0] err_count
);

  state_t      state;
  state_t      state_nxt;

  logic        we_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  size_q;

  logic        chk_err;
  logic        req_fire;
  logic        resp_fire;

  dmem_lsu_chk #(
    .DEPTH  (DEPTH),
    .REGION (REGION)
  ) u_chk (
    .addr (req_addr),
    .size (req_size),
    .we   (req_we),
    .err  (chk_err)
  );

  assign req_fire  = req_valid && req_ready;
  assign resp_fire = resp_valid && resp_ready;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the case leaves
  // state_nxt unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_fire) state_nxt = chk_err ? RESP : ISSUE;
      ISSUE:   state_nxt = we_q ? RESP : CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    mem_wEn    = (state == ISSUE) && we_q;
  end

  // Request latch, response data and completion counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= SZ_W;
      resp_rdata  <= '0;
      load_count  <= '0;
      store_count <= '0;
      err_count   <= '0;
    end else begin
      if (req_fire) begin
        we_q       <= req_we;
        err_q      <= chk_err;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        size_q     <= req_size;
        resp_rdata <= '0;
      end

      // dmem has already sign/zero-extended the read, so pass it through.
      if (state == CAPTURE) resp_rdata <= mem_rData;

      if (resp_fire) begin
        if (err_q)     err_count   <= err_count + 32'd1;
        else if (we_q) store_count <= store_count + 32'd1;
        else           load_count  <= load_count + 32'd1;
      end
    end
  end

  assign resp_err  = err_q;
  assign mem_addr  = addr_q;
  assign mem_size  = size_q;
  assign mem_wData = wdata_q;

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store initiator that drives the byte-addressed data memory port (`wData`/`rData`/`addr`/`size`/`wEn`) on behalf of the core pipeline. It accepts one request at a time over a valid/ready handshake and enforces the memory's one-cycle registered read latency. It also rejects unsupported sizes and out-of-range accesses before they reach memory, and returns a response over a second valid/ready handshake. It sits between the execute stage and `dmem`, and keeps per-type access counters for the benchmarking framework.

## Interface
- `DEPTH`, 128: memory size in KiB; the byte range is `DEPTH*1024`, and it must match the attached `dmem`.
- `REGION`, 4'h1: value that `addr[31:28]` must equal for an access to be in range.
- `clk`  in  1  clock; all logic is on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when high together with `req_valid`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_size`  in  3  funct3 encoding: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `req_wdata`  in  32  store data, LSB-aligned.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  core accepts the response.
- `resp_rdata`  out  32  load result, extended per size; 0 for stores and errors.
- `resp_err`  out  1  access rejected.
- `mem_wData`, `mem_addr`  out  32  to `dmem`.
- `mem_size`  out  3  to `dmem`.
- `mem_wEn`  out  1  to `dmem`.
- `mem_rData`  in  32  from `dmem`.
- `load_count`, `store_count`, `err_count`  out  32  completed-access counters; they wrap at 2^32.

## Operation
- State machine states: IDLE, ISSUE, CAPTURE, RESP.
- `req_ready` = (state == IDLE).
- IDLE, on handshake:
  - Latch `we`, `addr`, `size` and `wdata`.
  - Compute `err`. It is set when any of the following holds:
    - `addr[31:28] != REGION`.
    - The size code is not in {000, 001, 010, 100, 101}.
    - A store uses size 100 or 101.
    - `addr[27:0] + nbytes - 1 >= DEPTH*1024`, where nbytes is 1, 2 or 4; compute it 29 bits wide so it cannot overflow.
  - If `err`: go to RESP with `resp_err`=1 and `resp_rdata`=0. No memory cycle is issued.
  - Otherwise go to ISSUE.
- Misaligned addresses are legal; `dmem` handles byte-granular access.
- ISSUE:
  - `mem_addr`, `mem_size` and `mem_wData` are driven from the latched registers.
  - `mem_wEn` = latched `we`. This is the only state in which `mem_wEn` can be high.
  - Store: go to RESP.
  - Load: go to CAPTURE.
- CAPTURE:
  - `mem_rData` now holds the ISSUE-cycle read result.
  - Register it into `resp_rdata` unmodified; `dmem` already applies the sign or zero extension.
  - Go to RESP.
- RESP:
  - `resp_valid`=1. `resp_rdata` and `resp_err` are held stable until `resp_ready`.
  - On `resp_ready`, go to IDLE and, in the same edge, increment exactly one counter: `err_count` if err, else `store_count` or `load_count`.
- `mem_addr`, `mem_size` and `mem_wData` hold their latched values in every state except IDLE before the first request. `mem_wEn` is combinational from state and is never high outside ISSUE.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_wEn`=0, `mem_addr`=0, `mem_size`=3'b010, `mem_wData`=0, all counters 0.
- Latency, counted from the handshake edge T:
  - Store: ISSUE in cycle T+1; `resp_valid` in cycle T+2.
  - Load: ISSUE in T+1, CAPTURE in T+2; `resp_valid` in T+3.
  - Error: `resp_valid` in T+1.
- Throughput: one request per (latency + 1) cycles when `resp_ready` is held at 1. There is no overlap of requests.
- Reset asserted during ISSUE of a store: that cycle's `mem_wEn` is still high and the write still commits. State is IDLE after the edge, and no response or count is produced.
- Reset asserted in any state aborts the in-flight access. Outputs take their reset values on the following edge.
- `req_valid` is ignored outside IDLE. Requests may change freely while `req_ready`=0.

## Structure
- Package `dmem_pkg` holds:
  - The state enum.
  - Size localparams `SZ_B`, `SZ_H`, `SZ_W`, `SZ_BU`, `SZ_HU`.
  - A function mapping a size code to its byte count.
- Sub-module `dmem_lsu_chk` is purely combinational. It takes addr, size and we and produces err; it is unit-tested on its own.
- FSM, latches and counters stay in `dmem_lsu`.

## Test plan
- Reset: assert `rst` for 2 cycles. Then `req_ready`=1, `resp_valid`=0, `mem_wEn`=0, all counters 0.
- Store then load, with `dmem` attached and `resp_ready`=1:
  - sw 0xCAFEBABE at 0x1000_0010 gives exactly one `mem_wEn` pulse and `resp_valid` at T+2.
  - lw from 0x1000_0010 returns 0xCAFEBABE at T+3 with `resp_err`=0.
  - Afterwards `store_count`=1 and `load_count`=1.
- Byte extension: sb 0x80 at 0x1000_0003.
  - lb returns 0xFFFFFF80.
  - lbu returns 0x00000080.
  - A misaligned lh at 0x1000_0003 returns a sign-extended value with `resp_err`=0.
- Range and size errors, each with no `mem_wEn` pulse and a response at T+1 with `resp_err`=1 and `resp_rdata`=0; `err_count`=4 at the end:
  - lw at 0x1000_0000 + DEPTH*1024 - 2.
  - lw at 0x2000_0000.
  - Load with size 011.
  - Store with size 100.
- Backpressure: lw with `resp_ready` held low for 5 cycles.
  - `resp_valid`, `resp_rdata` and `resp_err` stay stable and `req_ready`=0 throughout.
  - Counter increments only on the accepting edge.
- Reset mid-access:
  - Assert `rst` during CAPTURE of a load: no response, `load_count` unchanged, `req_ready`=1 after the edge.
  - Assert `rst` during ISSUE of sw 0x12345678: memory still holds 0x12345678 afterwards.
